// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/shift/rotate/load/clear per cycle plus a counted burst engine.
// Ports: clk, rstn, mode, sin_lsb, sin_msb, pdata, start, count -> out, sout_msb, sout_lsb, busy, done.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [2:0]       lmode, lmode_n;
  logic [WIDTH-1:0] out_n;
  logic             done_n;

  // Unknown op codes fall to the default branch and hold the register.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] pd,
    input logic             sl,
    input logic             sm
  );
    case (op)
      3'b001:  apply_op = {v[WIDTH-2:0], sl};
      3'b010:  apply_op = {sm, v[WIDTH-1:1]};
      3'b011:  apply_op = {v[WIDTH-2:0], v[WIDTH-1]};
      3'b100:  apply_op = {v[0], v[WIDTH-1:1]};
      3'b101:  apply_op = pd;
      3'b110:  apply_op = {v[WIDTH-1], v[WIDTH-1:1]};
      3'b111:  apply_op = '0;
      default: apply_op = v;
    endcase
  endfunction

  function automatic logic is_shift(input logic [2:0] op);
    case (op)
      3'b001, 3'b010, 3'b011,
      3'b100, 3'b110: is_shift = 1'b1;
      default:        is_shift = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    rem_n   = rem;
    lmode_n = lmode;
    out_n   = out;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_shift(mode) && count != '0) begin
            state_n = BUSY;
            lmode_n = mode;
            rem_n   = count;
          end else begin
            // Keep done a single-cycle pulse even for a rejected
            // start issued in the completion cycle.
            done_n = ~done;
          end
        end else begin
          out_n = apply_op(mode, out, pdata, sin_lsb, sin_msb);
        end
      end
      BUSY: begin
        out_n = apply_op(lmode, out, pdata, sin_lsb, sin_msb);
        rem_n = rem - ONE;
        if (rem == ONE) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        rem_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      rem   <= '0;
      lmode <= 3'b000;
      out   <= RST_VAL;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      lmode <= lmode_n;
      out   <= out_n;
      done  <= done_n;
    end
  end

  assign busy     = (state == BUSY);
  assign sout_msb = out[WIDTH-1];
  assign sout_lsb = out[0];

endmodule
